// File: rtl/uart_mmio.sv
// Memory-mapped UART register block: RX/TX byte FIFOs between the CPU data bus
// and the UART transmitter/receiver ready/valid streams, with status and sticky overflow flags.
module uart_mmio #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data_out,
  output logic        tx_data_out_valid,
  input  logic        tx_data_out_ready,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_data_in_valid,
  output logic        rx_data_in_ready
);
  localparam int PTR_W = CNT_W - 1;
  localparam logic [3:0] ADDR_STATUS = 4'h0;
  localparam logic [3:0] ADDR_RXDATA = 4'h4;
  localparam logic [3:0] ADDR_TXDATA = 4'h8;

  logic [7:0]       rx_mem [0:FIFO_DEPTH-1];
  logic [7:0]       tx_mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
  logic [CNT_W-1:0] rx_count, tx_count;
  logic             rx_ovf, tx_ovf;
  logic             rx_full, rx_empty, tx_full, tx_empty;
  logic             rx_push, rx_pop, rx_drop, tx_push, tx_pop, tx_drop;
  logic             status_wr;
  logic [31:0]      status;

  assign rx_full  = (rx_count == CNT_W'(FIFO_DEPTH));
  assign rx_empty = (rx_count == '0);
  assign tx_full  = (tx_count == CNT_W'(FIFO_DEPTH));
  assign tx_empty = (tx_count == '0);

  // A same-cycle pop frees the slot, so a push into a full FIFO is accepted then.
  assign rx_pop  = re && (addr == ADDR_RXDATA) && !rx_empty;
  assign rx_push = rx_data_in_valid && (!rx_full || rx_pop);
  assign rx_drop = rx_data_in_valid && rx_full && !rx_pop;

  assign tx_pop  = !tx_empty && tx_data_out_ready;
  assign tx_push = we && (addr == ADDR_TXDATA) && (!tx_full || tx_pop);
  assign tx_drop = we && (addr == ADDR_TXDATA) && tx_full && !tx_pop;

  assign status_wr = we && (addr == ADDR_STATUS);

  assign rx_data_in_ready  = 1'b1;
  assign tx_data_out_valid = !tx_empty;
  assign tx_data_out       = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];

  always_comb begin
    status               = '0;
    status[0]            = !rx_empty;
    status[1]            = !tx_full;
    status[2]            = rx_ovf;
    status[3]            = tx_ovf;
    status[8 +: CNT_W]   = rx_count;
    status[16 +: CNT_W]  = tx_count;
  end

  // Storage carries no reset; the counts alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data_in;
    if (tx_push) tx_mem[tx_wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_count  <= '0;
      tx_count  <= '0;
      rx_ovf    <= 1'b0;
      tx_ovf    <= 1'b0;
      rdata     <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
      rx_count <= rx_count + CNT_W'(rx_push) - CNT_W'(rx_pop);
      tx_count <= tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop);

      // A drop in the same cycle as a firmware clear keeps the flag set.
      if (rx_drop)                      rx_ovf <= 1'b1;
      else if (status_wr && wdata[2])   rx_ovf <= 1'b0;
      if (tx_drop)                      tx_ovf <= 1'b1;
      else if (status_wr && wdata[3])   tx_ovf <= 1'b0;

      if (re) begin
        case (addr)
          ADDR_STATUS: rdata <= status;
          ADDR_RXDATA: rdata <= rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd_ptr]};
          default:     rdata <= 32'h0;
        endcase
      end
    end
  end
endmodule
